// File: rtl/cluster_clock_gate_ctrl_pkg.sv
// Shared types and default parameters for the cluster clock-gate controller.
package cluster_cg_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    GATED = 2'd1,
    WAKE  = 2'd2
  } cg_state_e;

  localparam int DEF_IDLE_CNT_W  = 8;
  localparam int DEF_WAKE_CYCLES = 2;
  localparam int DEF_STAT_W      = 16;

endpackage

// File: rtl/cluster_clock_gate_ctrl.sv
// Idle-detection controller driving the cluster clock-gate enable; runs on the
// free-running cluster clock and wakes with a fixed settle window before ack.
module cluster_clock_gate_ctrl
  import cluster_cg_pkg::*;
#(
  parameter int IDLE_CNT_W  = DEF_IDLE_CNT_W,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int STAT_W      = DEF_STAT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_en_i,
  input  logic [IDLE_CNT_W-1:0] cfg_idle_thr_i,
  input  logic                  force_on_i,
  input  logic                  busy_i,
  input  logic                  wake_req_i,
  output logic                  wake_ack_o,
  output logic                  clk_en_o,
  output logic                  gated_o,
  input  logic                  stat_clr_i,
  output logic [STAT_W-1:0]     stat_gate_cnt_o,
  output cg_state_e             dbg_state_o
);

  // Wake handshake: wake_req_i is a level held by the requester until it sees
  // wake_ack_o high; wake_ack_o is high exactly while the clock is enabled and
  // settled (RUN), so a request raised in RUN is acknowledged in that cycle.

  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

  cg_state_e             state_q, state_d;
  logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [3:0]            wake_cnt_q, wake_cnt_d;
  logic [STAT_W-1:0]     stat_q, stat_d;
  logic                  clk_en_q;
  logic                  idle;
  logic                  gate_event;

  assign idle = cfg_en_i & ~force_on_i & ~busy_i & ~wake_req_i;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    gate_event = 1'b0;
    case (state_q)
      RUN: begin
        if (idle) begin
          if (idle_cnt_q != '1) idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
          // >= so a threshold lowered mid-count gates on the next idle cycle
          if (idle_cnt_q >= cfg_idle_thr_i) begin
            state_d    = GATED;
            gate_event = 1'b1;
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      GATED: begin
        idle_cnt_d = '0;
        if (busy_i | wake_req_i | ~cfg_en_i | force_on_i) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        wake_cnt_d = wake_cnt_q + 4'd1;
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RUN;
        idle_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stat_d = stat_q;
    if (stat_clr_i)      stat_d = '0;
    else if (gate_event) stat_d = stat_q + STAT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      stat_q     <= '0;
      clk_en_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      stat_q     <= stat_d;
      // Enable is a pure flop output so the gate cell latch sees no glitches
      clk_en_q   <= (state_d != GATED);
    end
  end

  assign clk_en_o        = clk_en_q;
  assign gated_o         = (state_q == GATED);
  assign wake_ack_o      = (state_q == RUN);
  assign stat_gate_cnt_o = stat_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Directed bench for cluster_clock_gate_ctrl: the driver pushes the expected
// post-edge outputs per cycle; a monitor pops and compares after each edge.
module tb_cluster_clock_gate_ctrl;
  import cluster_cg_pkg::*;

  localparam int IDLE_CNT_W  = 8;
  localparam int WAKE_CYCLES = 2;
  localparam int STAT_W      = 8;
  localparam int EW          = 21;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cfg_en = 1'b0;
  logic [IDLE_CNT_W-1:0] thr = '0;
  logic                  force_on = 1'b0;
  logic                  busy = 1'b0;
  logic                  wake_req = 1'b0;
  logic                  stat_clr = 1'b0;
  logic                  wake_ack;
  logic                  clk_en;
  logic                  gated;
  logic [STAT_W-1:0]     stat_cnt;
  cg_state_e             dbg_state;

  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [15:0]   exp_stat = '0;

  cluster_clock_gate_ctrl #(
    .IDLE_CNT_W (IDLE_CNT_W),
    .WAKE_CYCLES(WAKE_CYCLES),
    .STAT_W     (STAT_W)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cfg_en_i       (cfg_en),
    .cfg_idle_thr_i (thr),
    .force_on_i     (force_on),
    .busy_i         (busy),
    .wake_req_i     (wake_req),
    .wake_ack_o     (wake_ack),
    .clk_en_o       (clk_en),
    .gated_o        (gated),
    .stat_clr_i     (stat_clr),
    .stat_gate_cnt_o(stat_cnt),
    .dbg_state_o    (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Expected entry: {state[1:0], clk_en, gated, wake_ack, stat[15:0]}
  function automatic logic [EW-1:0] pack_exp(input cg_state_e st, input logic [15:0] st_cnt);
    logic en, g, ack;
    en  = (st != GATED);
    g   = (st == GATED);
    ack = (st == RUN);
    return {st, en, g, ack, st_cnt};
  endfunction

  // Driver: inputs already set at the negedge; push expectation for the next edge
  task automatic tick(input cg_state_e st);
    exp_q.push_back(pack_exp(st, exp_stat));
    @(negedge clk);
  endtask

  task automatic ticks(input int n, input cg_state_e st);
    for (int i = 0; i < n; i++) tick(st);
  endtask

  // Leave GATED via busy and settle back into RUN
  task automatic wake_by_busy();
    busy = 1'b1;
    tick(WAKE);
    tick(WAKE);
    tick(RUN);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [EW-1:0] exp_e, got_e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        got_e = {dbg_state, clk_en, gated, wake_ack, 16'(stat_cnt)};
        checks++;
        if (got_e !== exp_e) begin
          errors++;
          $display("FAIL outputs t=%0t got st=%0d en=%b gated=%b ack=%b stat=%0d exp st=%0d en=%b gated=%b ack=%b stat=%0d",
                   $time, got_e[20:19], got_e[18], got_e[17], got_e[16], got_e[15:0],
                   exp_e[20:19], exp_e[18], exp_e[17], exp_e[16], exp_e[15:0]);
        end
      end
    end
  end

  initial begin
    int budget;
    @(negedge clk);

    // 1: reset, then auto-gating disabled for 100 cycles
    ticks(3, RUN);
    rst_n = 1'b1;
    ticks(100, RUN);

    // 2: thr=3, idle from cycle 0 -> gated after edge of cycle 3
    cfg_en = 1'b1;
    thr    = 8'd3;
    ticks(3, RUN);
    exp_stat = 16'd1;
    ticks(3, GATED);

    // 3: wake request held in GATED -> enable next cycle, ack two cycles later
    wake_req = 1'b1;
    tick(WAKE);
    tick(WAKE);
    tick(RUN);
    wake_req = 1'b0;
    ticks(3, RUN);
    exp_stat = 16'd2;
    tick(GATED);

    // 4: thr=10 with busy every 5th cycle never gates; then lower thr at idle_cnt=4
    wake_by_busy();
    thr = 8'd10;
    for (int i = 0; i < 30; i++) begin
      busy = (i % 5 == 4);
      tick(RUN);
    end
    busy = 1'b0;
    ticks(4, RUN);
    thr = 8'd2;
    exp_stat = 16'd3;
    tick(GATED);

    // 5: force_on wakes and prevents gating; reset mid-WAKE returns to RUN
    force_on = 1'b1;
    tick(WAKE);
    tick(WAKE);
    tick(RUN);
    thr = 8'd0;
    ticks(5, RUN);
    force_on = 1'b0;
    exp_stat = 16'd4;
    tick(GATED);
    busy = 1'b1;
    tick(WAKE);
    rst_n = 1'b0;
    exp_stat = 16'd0;
    tick(RUN);
    rst_n = 1'b1;
    tick(RUN);

    // Wake request in RUN blocks counting; busy falling as wake rises is not idle
    busy     = 1'b0;
    wake_req = 1'b1;
    thr      = 8'd1;
    ticks(3, RUN);
    busy     = 1'b1;
    wake_req = 1'b0;
    tick(RUN);
    busy     = 1'b0;
    wake_req = 1'b1;
    tick(RUN);
    wake_req = 1'b0;
    tick(RUN);
    exp_stat = 16'd1;
    tick(GATED);
    wake_by_busy();

    // 6: clear, 2^STAT_W gate events wrap to 0, then clear coinciding with a gate
    stat_clr = 1'b1;
    exp_stat = 16'd0;
    tick(RUN);
    stat_clr = 1'b0;
    thr = 8'd0;
    for (int k = 1; k <= (1 << STAT_W) + 1; k++) begin
      busy = 1'b0;
      exp_stat = 16'(k % (1 << STAT_W));
      tick(GATED);
      wake_by_busy();
    end
    busy     = 1'b0;
    stat_clr = 1'b1;
    exp_stat = 16'd0;
    tick(GATED);
    stat_clr = 1'b0;
    wake_by_busy();

    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
